// File: rtl/riscv_mem_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, owner tags and the
// muxed memory request bundle presented to the single-ported macro.
package riscv_mem_pkg;

  localparam int MAX_MEM_LAT = 4;

  // Core bus widths; the arbiter's ADDR_W/DATA_W may not exceed these.
  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = BUS_DATA_W / 8;

  // Bit positions inside the arbiter's grant vector.
  localparam int GNT_IF = 0;
  localparam int GNT_D  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef struct packed {
    logic [BUS_BE_W-1:0]   we;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_IF) ? OWN_D : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// arb_pick: combinational grant policy for the memory arbiter. MEM_ARB_RR_EN
// selects strict round-robin; otherwise data wins unless fetch is starved.
module arb_pick
  import riscv_mem_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  logic       starve,
  input  owner_e     last_owner,
  output logic [1:0] gnt
);

`ifdef MEM_ARB_RR_EN
  logic unused_starve;
  assign unused_starve = starve;

  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    gnt = '0;
    if (if_req && d_req) begin
      if (other_owner(last_owner) == OWN_IF) gnt[GNT_IF] = 1'b1;
      else                                   gnt[GNT_D]  = 1'b1;
    end else if (d_req) begin
      gnt[GNT_D] = 1'b1;
    end else if (if_req) begin
      gnt[GNT_IF] = 1'b1;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    gnt = '0;
    if (if_req && (starve || !d_req)) gnt[GNT_IF] = 1'b1;
    else if (d_req)                   gnt[GNT_D]  = 1'b1;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency single-ported memory between fetch and
// load/store. Optional build macro MEM_ARB_RR_EN swaps data priority for round-robin.
module mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,

  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,

  output logic                m_en,
  output logic [DATA_W/8-1:0] m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LAT_W = $clog2(MAX_MEM_LAT);
  localparam logic [LAT_W-1:0] LAT_INIT = (MEM_LAT > 1) ? LAT_W'(MEM_LAT - 2) : '0;

  arb_state_e       state_q, state_d;
  owner_e           owner_q;
  logic             store_q;
  logic [LAT_W-1:0] lat_cnt_q;

  logic       arb_slot;
  logic       starve;
  owner_e     last_owner;
  logic [1:0] pick;
  logic       grant_if, grant_d, grant_any;
  logic       resp;
  mem_req_t   req;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign arb_slot = (state_q == IDLE) || (state_q == RESP);

  arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .starve     (starve),
    .last_owner (last_owner),
    .gnt        (pick)
  );

  // Grants are qualified by reset_n so every output reads 0 while reset is
  // held, even though the requesters may still be driving.
  assign grant_if  = reset_n && arb_slot && pick[GNT_IF];
  assign grant_d   = reset_n && arb_slot && pick[GNT_D];
  assign grant_any = grant_if || grant_d;

`ifdef MEM_ARB_RR_EN
  owner_e last_owner_q;

  // Reset to fetch so the first contested grant goes to data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       last_owner_q <= OWN_IF;
    else if (grant_any) last_owner_q <= other_owner(last_owner_q);
  end

  assign last_owner = last_owner_q;
  assign starve     = 1'b0;
`else
  localparam int ST_W = $clog2(STARVE_MAX + 1);
  logic [ST_W-1:0] starve_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_q <= '0;
    end else if (!if_req || grant_if) begin
      starve_cnt_q <= '0;
    end else if (grant_d && (starve_cnt_q != ST_W'(STARVE_MAX))) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end

  assign starve     = (starve_cnt_q == ST_W'(STARVE_MAX));
  assign last_owner = OWN_IF;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (grant_any) state_d = (MEM_LAT == 1) ? RESP : WAIT;
        else           state_d = IDLE;
      end
      WAIT: begin
        if (lat_cnt_q == '0) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transaction bookkeeping captured at the grant edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q   <= OWN_IF;
      store_q   <= 1'b0;
      lat_cnt_q <= '0;
    end else if (grant_any) begin
      owner_q   <= grant_d ? OWN_D : OWN_IF;
      store_q   <= grant_d && (d_we != '0);
      lat_cnt_q <= LAT_INIT;
    end else if ((state_q == WAIT) && (lat_cnt_q != '0)) begin
      lat_cnt_q <= lat_cnt_q - 1'b1;
    end
  end

  // Fetch requests never write, so only the address is taken from if_*.
  always_comb begin
    req = '0;
    if (grant_d) begin
      req.we    = BUS_BE_W'(d_we);
      req.addr  = BUS_ADDR_W'(d_addr);
      req.wdata = BUS_DATA_W'(d_wdata);
    end else if (grant_if) begin
      req.addr  = BUS_ADDR_W'(if_addr);
    end
  end

  assign resp = reset_n && (state_q == RESP);

  always_comb begin
    if_gnt    = grant_if;
    d_gnt     = grant_d;
    m_en      = grant_any;
    m_we      = BE_W'(req.we);
    m_addr    = ADDR_W'(req.addr);
    m_wdata   = DATA_W'(req.wdata);
    if_rvalid = resp && (owner_q == OWN_IF);
    d_rvalid  = resp && (owner_q == OWN_D);
    if_rdata  = if_rvalid ? m_rdata : '0;
    d_rdata   = (d_rvalid && !store_q) ? m_rdata : '0;
  end

  // ---------------------------------------------------------------------------
  // Protocol invariants
  // ---------------------------------------------------------------------------
  a_one_gnt : assert property (@(posedge clk) disable iff (!reset_n)
    !(if_gnt && d_gnt));

  a_one_rvalid : assert property (@(posedge clk) disable iff (!reset_n)
    !(if_rvalid && d_rvalid));

  a_no_grant_in_wait : assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == WAIT) |-> !m_en);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter with a small memory model;
// a MEM_LAT=1 instance covers arbitration and a MEM_LAT=3 instance covers reset in WAIT.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- MEM_LAT = 1 instance ----------------
  logic          reset_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic [BW-1:0] d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_en;
  logic [BW-1:0] m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .m_en      (m_en),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata)
  );

  // Word memory, one-cycle registered read, byte-enabled write.
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rd_q;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h04] = 32'h0050_0093;  // 0x010
    mem[8'h08] = 32'h0000_0013;  // 0x020
    mem[8'h10] = 32'h1122_3344;  // 0x040
    mem[8'h80] = 32'h1234_5678;  // 0x200
  end

  always @(posedge clk) begin
    if (m_en) begin
      rd_q <= mem[m_addr[9:2]];
      for (int b = 0; b < BW; b++)
        if (m_we[b]) mem[m_addr[9:2]][8*b +: 8] = m_wdata[8*b +: 8];
    end
  end
  assign m_rdata = rd_q;

  // ---------------- MEM_LAT = 3 instance ----------------
  logic          l3_reset_n;
  logic          l3_if_req;
  logic [AW-1:0] l3_if_addr;
  logic          l3_if_gnt, l3_if_rvalid;
  logic [DW-1:0] l3_if_rdata;
  logic          l3_d_req;
  logic [BW-1:0] l3_d_we;
  logic [AW-1:0] l3_d_addr;
  logic [DW-1:0] l3_d_wdata;
  logic          l3_d_gnt, l3_d_rvalid;
  logic [DW-1:0] l3_d_rdata;
  logic          l3_m_en;
  logic [BW-1:0] l3_m_we;
  logic [AW-1:0] l3_m_addr;
  logic [DW-1:0] l3_m_wdata;
  logic [DW-1:0] l3_m_rdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(4)) u_dut_lat3 (
    .clk       (clk),
    .reset_n   (l3_reset_n),
    .if_req    (l3_if_req),
    .if_addr   (l3_if_addr),
    .if_gnt    (l3_if_gnt),
    .if_rvalid (l3_if_rvalid),
    .if_rdata  (l3_if_rdata),
    .d_req     (l3_d_req),
    .d_we      (l3_d_we),
    .d_addr    (l3_d_addr),
    .d_wdata   (l3_d_wdata),
    .d_gnt     (l3_d_gnt),
    .d_rvalid  (l3_d_rvalid),
    .d_rdata   (l3_d_rdata),
    .m_en      (l3_m_en),
    .m_we      (l3_m_we),
    .m_addr    (l3_m_addr),
    .m_wdata   (l3_m_wdata),
    .m_rdata   (l3_m_rdata)
  );

  // Three-stage read pipe; data word is the address XOR a fixed tag.
  logic [DW-1:0] l3_pipe [0:2];
  always @(posedge clk) begin
    l3_pipe[0] <= l3_m_en ? (l3_m_addr ^ 32'hA5A5_0000) : '0;
    l3_pipe[1] <= l3_pipe[0];
    l3_pipe[2] <= l3_pipe[1];
  end
  assign l3_m_rdata = l3_pipe[2];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic exp_if, prev_if;

  initial begin
    reset_n    = 1'b0;  l3_reset_n = 1'b0;
    if_req     = 1'b1;  if_addr    = 32'h10;
    d_req      = 1'b1;  d_we       = '0;  d_addr = 32'h200;  d_wdata = '0;
    l3_if_req  = 1'b0;  l3_if_addr = '0;
    l3_d_req   = 1'b0;  l3_d_we    = '0;  l3_d_addr = '0;  l3_d_wdata = '0;

    // Reset: outputs stay 0 even with both requests asserted.
    #3;
    check("rst_if_gnt",   if_gnt,    0);
    check("rst_d_gnt",    d_gnt,     0);
    check("rst_m_en",     m_en,      0);
    check("rst_m_addr",   m_addr,    0);
    check("rst_rvalids",  {if_rvalid, d_rvalid}, 0);
    repeat (2) @(posedge clk);
    #1;
    if_req = 1'b0;  d_req = 1'b0;  d_addr = '0;
    reset_n = 1'b1;  l3_reset_n = 1'b1;

    // Single fetch.
    cyc();
    if_req = 1'b1;  if_addr = 32'h10;
    #1;
    check("f1_if_gnt",  if_gnt,  1);
    check("f1_d_gnt",   d_gnt,   0);
    check("f1_m_en",    m_en,    1);
    check("f1_m_addr",  m_addr,  32'h10);
    check("f1_m_we",    m_we,    0);
    check("f1_m_wdata", m_wdata, 0);
    cyc();
    if_req = 1'b0;
    #1;
    check("f1_if_rvalid", if_rvalid, 1);
    check("f1_if_rdata",  if_rdata,  32'h0050_0093);
    check("f1_d_rvalid",  d_rvalid,  0);
    check("f1_resp_m_en", m_en,      0);
    cyc();
    #1;
    check("f1_idle_rvalid", if_rvalid, 0);
    check("f1_idle_m_addr", m_addr,    0);

`ifndef MEM_ARB_RR_EN
    // Contention: data first, fetch granted in the data RESP cycle.
    cyc();
    if_req = 1'b1;  if_addr = 32'h20;
    d_req  = 1'b1;  d_we = '0;  d_addr = 32'h200;
    #1;
    check("c_d_gnt",   d_gnt,  1);
    check("c_if_gnt0", if_gnt, 0);
    check("c_m_addr0", m_addr, 32'h200);
    cyc();
    d_req = 1'b0;
    #1;
    check("c_d_rvalid",  d_rvalid,  1);
    check("c_d_rdata",   d_rdata,   32'h1234_5678);
    check("c_if_gnt1",   if_gnt,    1);
    check("c_m_addr1",   m_addr,    32'h20);
    check("c_if_rvalid0", if_rvalid, 0);
    cyc();
    if_req = 1'b0;
    #1;
    check("c_if_rvalid1", if_rvalid, 1);
    check("c_if_rdata",   if_rdata,  32'h0000_0013);
    check("c_d_rvalid1",  d_rvalid,  0);
    cyc();

    // Starvation: fetch wins every 5th arbitration with d_req held high.
    cyc();
    if_req = 1'b1;  if_addr = 32'h10;
    d_req  = 1'b1;  d_we = '0;  d_addr = 32'h200;
    prev_if = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_if = (i % 5 == 4);
      check($sformatf("st_if_gnt_%0d", i), if_gnt, exp_if);
      check($sformatf("st_d_gnt_%0d", i),  d_gnt,  !exp_if);
      if (i > 0) begin
        check($sformatf("st_d_rvalid_%0d", i),  d_rvalid,  !prev_if);
        check($sformatf("st_if_rvalid_%0d", i), if_rvalid, prev_if);
      end
      prev_if = exp_if;
      cyc();
    end
    if_req = 1'b0;  d_req = 1'b0;
    #1;
    check("st_last_if_rvalid", if_rvalid, 1);
    check("st_last_if_rdata",  if_rdata,  32'h0050_0093);
    check("st_last_m_en",      m_en,      0);
`endif

    // Partial store, then read back the merged word.
    cyc();
    d_req = 1'b1;  d_we = 4'b0011;  d_wdata = 32'hDEAD_BEEF;  d_addr = 32'h40;
    #1;
    check("s_d_gnt",   d_gnt,   1);
    check("s_m_en",    m_en,    1);
    check("s_m_we",    m_we,    4'b0011);
    check("s_m_wdata", m_wdata, 32'hDEAD_BEEF);
    check("s_m_addr",  m_addr,  32'h40);
    cyc();
    d_req = 1'b0;  d_we = '0;  d_wdata = '0;
    #1;
    check("s_d_rvalid", d_rvalid, 1);
    check("s_d_rdata",  d_rdata,  0);
    check("s_if_rvalid", if_rvalid, 0);
    cyc();
    d_req = 1'b1;  d_addr = 32'h40;
    #1;
    check("ld_d_gnt",   d_gnt,   1);
    check("ld_m_we",    m_we,    0);
    check("ld_m_wdata", m_wdata, 0);
    cyc();
    d_req = 1'b0;
    #1;
    check("ld_d_rvalid", d_rvalid, 1);
    check("ld_d_rdata",  d_rdata,  32'h1122_BEEF);

    // MEM_LAT = 3: full fetch latency.
    cyc();
    l3_if_req = 1'b1;  l3_if_addr = 32'h100;
    #1;
    check("l3_gnt",  l3_if_gnt, 1);
    check("l3_m_en", l3_m_en,   1);
    cyc();
    l3_if_req = 1'b0;
    #1;
    check("l3_wait1_rvalid", l3_if_rvalid, 0);
    cyc();
    #1;
    check("l3_wait2_rvalid", l3_if_rvalid, 0);
    check("l3_wait2_m_en",   l3_m_en,      0);
    cyc();
    #1;
    check("l3_rvalid", l3_if_rvalid, 1);
    check("l3_rdata",  l3_if_rdata,  32'hA5A5_0100);

    // MEM_LAT = 3: reset asserted mid-WAIT drops the transaction.
    cyc();
    l3_if_req = 1'b1;  l3_if_addr = 32'h104;
    #1;
    check("l3r_gnt", l3_if_gnt, 1);
    cyc();
    l3_reset_n = 1'b0;
    #1;
    check("l3r_if_gnt",   l3_if_gnt,    0);
    check("l3r_m_en",     l3_m_en,      0);
    check("l3r_m_addr",   l3_m_addr,    0);
    check("l3r_rvalids",  {l3_if_rvalid, l3_d_rvalid, l3_d_gnt}, 0);
    check("l3r_rdata",    l3_if_rdata,  0);
    l3_if_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 2) l3_reset_n = 1'b1;
      #1;
      check($sformatf("l3r_no_rvalid_%0d", i), l3_if_rvalid, 0);
    end
    l3_if_req = 1'b1;  l3_if_addr = 32'h108;
    #1;
    check("l3n_gnt",    l3_if_gnt, 1);
    check("l3n_m_addr", l3_m_addr, 32'h108);
    cyc();
    l3_if_req = 1'b0;
    cyc();
    cyc();
    #1;
    check("l3n_rvalid", l3_if_rvalid, 1);
    check("l3n_rdata",  l3_if_rdata,  32'hA5A5_0108);

`ifdef MEM_ARB_RR_EN
    // Round-robin: both held, grants alternate D, IF, D, IF.
    cyc();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    if_req = 1'b1;  if_addr = 32'h10;
    d_req  = 1'b1;  d_we = '0;  d_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr_d_gnt_%0d", i),  d_gnt,  (i % 2 == 0));
      check($sformatf("rr_if_gnt_%0d", i), if_gnt, (i % 2 == 1));
      cyc();
    end
    if_req = 1'b0;  d_req = 1'b0;
`endif

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
